// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: byte push handshake, FIFO flush
// and FIFO occupancy. The bus master drives bytes in; the transmitter
// reports back whether it can accept them.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       wdata_i;
  logic             wvalid_i;
  logic             wready_o;
  logic             fifo_clr_i;
  logic [LVL_W-1:0] fifo_lvl_o;

  modport master (
    output wdata_i, wvalid_i, fifo_clr_i,
    input  wready_o, fifo_lvl_o
  );

  modport slave (
    input  wdata_i, wvalid_i, fifo_clr_i,
    output wready_o, fifo_lvl_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal byte FIFO. The frame format (5-8 data
// bits, optional even/odd parity, 1 or 2 stop bits) and the bit period are
// latched when a byte is popped and held for the whole frame. Frames follow
// each other with no idle gap while the FIFO holds data and tx_en_i is high.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tx_en_i,
  input  logic [CNT_W-1:0] clks_per_bit_i,
  input  logic [1:0]       nbits_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop2_i,
  uart_tx_fifo_if.slave    wr,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e state_q, state_d;

  // FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] level_q;
  logic             wready, push, pop;

  // Frame latched at pop time
  logic [7:0]       data_q;
  logic [1:0]       nbits_q;
  logic             par_en_q, par_odd_q, stop2_q;
  logic [CNT_W-1:0] cpb_q;

  // Bit timing
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic             tx_q, tx_d;

  logic             bit_end, last_data, last_stop, start_ok, parity_bit;
  logic [7:0]       data_mask;

  assign wready        = (level_q != FULL_LVL);
  assign wr.wready_o   = wready;
  assign wr.fifo_lvl_o = level_q;
  // A flush wins over a same-cycle push; a push while full is dropped.
  assign push          = wr.wvalid_i && wready && !wr.fifo_clr_i;

  assign bit_end    = (cnt_q == cpb_q - CNT_W'(1));
  assign last_data  = (bit_idx_q == ({1'b0, nbits_q} + 3'd4));
  assign last_stop  = !stop2_q || stop_idx_q;
  assign start_ok   = tx_en_i && (level_q != '0);
  assign data_mask  = 8'hFF >> (2'd3 - nbits_q);
  assign parity_bit = (^(data_q & data_mask)) ^ par_odd_q;

  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);

  // FIFO storage write port
  // NOTE: the storage array has no reset; the level and pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= wr.wdata_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (wr.fifo_clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, next line level, pop request and end-of-frame pulse
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d = state_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (!last_data) begin
            tx_d = data_q[bit_idx_q + 3'd1];
          end else if (par_en_q) begin
            state_d = PARITY;
            tx_d    = parity_bit;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end && last_stop) begin
          done_o = 1'b1;
          if (start_ok) begin
            pop     = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit-period counter, bit indices, line register and frame latch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      data_q     <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      cpb_q      <= CNT_W'(1);
    end else begin
      tx_q  <= tx_d;
      cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + CNT_W'(1);

      if (state_q != DATA) bit_idx_q <= '0;
      else if (bit_end)    bit_idx_q <= bit_idx_q + 3'd1;

      if (state_q != STOP) stop_idx_q <= 1'b0;
      else if (bit_end)    stop_idx_q <= ~stop_idx_q;

      if (pop) begin
        data_q    <= mem[rptr_q];
        nbits_q   <= nbits_i;
        par_en_q  <= parity_en_i;
        par_odd_q <= parity_odd_i;
        stop2_q   <= stop2_i;
        // A zero divider behaves as one clock per bit.
        cpb_q     <= (clks_per_bit_i == '0) ? CNT_W'(1) : clks_per_bit_i;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A queue-based model predicts the
// line waveform cycle by cycle: each popped byte expands into a list of
// per-cycle line levels (start, data LSB first, parity, stops, each repeated
// N times). One compare process checks all outputs every cycle; directed
// scenarios add hand-computed literal expectations.
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             tx_en;
  logic [CNT_W-1:0] cpb;
  logic [1:0]       nbits;
  logic             par_en, par_odd, stop2;
  logic             tx, busy, done;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) wr ();

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tx_en_i        (tx_en),
    .clks_per_bit_i (cpb),
    .nbits_i        (nbits),
    .parity_en_i    (par_en),
    .parity_odd_i   (par_odd),
    .stop2_i        (stop2),
    .wr             (wr),
    .tx_o           (tx),
    .busy_o         (busy),
    .done_o         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] fifo_m[$];
  bit         wave_m[$];

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] b;
    bit         start_ok, push_ok, p;
    int         n, nb;
    bit         frame[$];
    if (!rst_n) begin
      fifo_m.delete();
      wave_m.delete();
    end else begin
      start_ok = tx_en && (fifo_m.size() > 0) && (wave_m.size() <= 1);
      push_ok  = wr.wvalid_i && (fifo_m.size() != DEPTH) && !wr.fifo_clr_i;
      if (wave_m.size() > 0) void'(wave_m.pop_front());
      if (start_ok) begin
        b  = fifo_m.pop_front();
        n  = (cpb == 0) ? 1 : int'(cpb);
        nb = 5 + int'(nbits);
        frame.delete();
        frame.push_back(1'b0);
        for (int i = 0; i < nb; i++) frame.push_back(b[i]);
        if (par_en) begin
          p = par_odd;
          for (int i = 0; i < nb; i++) p ^= b[i];
          frame.push_back(p);
        end
        frame.push_back(1'b1);
        if (stop2) frame.push_back(1'b1);
        foreach (frame[k]) for (int j = 0; j < n; j++) wave_m.push_back(frame[k]);
      end
      if (wr.fifo_clr_i) fifo_m.delete();
      else if (push_ok)  fifo_m.push_back(wr.wdata_i);
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("tx_o",       32'(tx),              32'((wave_m.size() > 0) ? wave_m[0] : 1'b1));
      check("busy_o",     32'(busy),            32'(wave_m.size() > 0));
      check("done_o",     32'(done),            32'(wave_m.size() == 1));
      check("wready_o",   32'(wr.wready_o),     32'(fifo_m.size() != DEPTH));
      check("fifo_lvl_o", 32'(wr.fifo_lvl_o),   32'(fifo_m.size()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr.wvalid_i = 1'b1;
    wr.wdata_i  = b;
    @(negedge clk);
    wr.wvalid_i = 1'b0;
  endtask

  task automatic set_cfg(input int n, input logic [1:0] nb, input logic pe,
                         input logic po, input logic s2);
    cpb     = CNT_W'(n);
    nbits   = nb;
    par_en  = pe;
    par_odd = po;
    stop2   = s2;
  endtask

  // Record one burst of busy cycles; sample the line at the start of each bit.
  task automatic capture(input int n, output int busy_cyc, output int dones,
                         output logic [31:0] bits, output int nsamp);
    bit started;
    int t;
    busy_cyc = 0; dones = 0; bits = '0; nsamp = 0; started = 0;
    for (t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (busy) begin
        started = 1;
        if ((busy_cyc % n) == 0 && nsamp < 32) begin
          bits[nsamp] = tx;
          nsamp++;
        end
        busy_cyc++;
        if (done) dones++;
      end else if (started) begin
        break;
      end
    end
    check("capture_bounded", 32'(t < 2000), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int          bc, dn, ns, cyc, t;
    bit          started;
    logic [31:0] bits;

    rst_n = 1'b0;
    tx_en = 1'b0;
    set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
    wr.wvalid_i   = 1'b0;
    wr.wdata_i    = '0;
    wr.fifo_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx",     32'(tx),            32'd1);
    check("rst_busy",   32'(busy),          32'd0);
    check("rst_done",   32'(done),          32'd0);
    check("rst_wready", 32'(wr.wready_o),   32'd1);
    check("rst_lvl",    32'(wr.fifo_lvl_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8N1, N=4, byte 0xA5
    tx_en = 1'b1;
    push(8'hA5);
    capture(4, bc, dn, bits, ns);
    check("a5_busy_cycles", 32'(bc), 32'd40);
    check("a5_dones",       32'(dn), 32'd1);
    check("a5_nbits",       32'(ns), 32'd10);
    check("a5_sequence",    bits,    32'h34A);
    check("a5_lvl_after",   32'(wr.fifo_lvl_o), 32'd0);

    // 7E2, N=3, byte 0x41: 3 x (start + 7 data + parity + 2 stop)
    set_cfg(3, 2'b10, 1'b1, 1'b0, 1'b1);
    push(8'h41);
    capture(3, bc, dn, bits, ns);
    check("7e2_busy_cycles", 32'(bc), 32'd33);
    check("7e2_dones",       32'(dn), 32'd1);
    check("7e2_sequence",    bits,    32'b110_1000_0010);
    check("7e2_parity",      32'(bits[8]), 32'd0);

    // 5O1, N=2, three queued bytes sent back to back
    tx_en = 1'b0;
    set_cfg(2, 2'b00, 1'b1, 1'b1, 1'b0);
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    check("5o1_lvl_queued", 32'(wr.fifo_lvl_o), 32'd3);
    tx_en = 1'b1;
    capture(2, bc, dn, bits, ns);
    check("5o1_busy_cycles", 32'(bc), 32'd48);
    check("5o1_dones",       32'(dn), 32'd3);
    check("5o1_parity0",     32'(bits[6]),  32'd1);
    check("5o1_parity1",     32'(bits[14]), 32'd0);
    check("5o1_parity2",     32'(bits[22]), 32'd0);
    check("5o1_start1",      32'(bits[8]),  32'd0);

    // Fill past full with transmission disabled, then flush with a push
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wr.wvalid_i = 1'b1;
      wr.wdata_i  = 8'(i + 16);
      if (i == 8) begin
        check("full_wready", 32'(wr.wready_o),   32'd0);
        check("full_lvl",    32'(wr.fifo_lvl_o), 32'd8);
      end
    end
    @(negedge clk);
    wr.wvalid_i = 1'b0;
    check("full_drop_lvl", 32'(wr.fifo_lvl_o), 32'd8);
    @(negedge clk);
    wr.fifo_clr_i = 1'b1;
    wr.wvalid_i   = 1'b1;
    @(negedge clk);
    wr.fifo_clr_i = 1'b0;
    wr.wvalid_i   = 1'b0;
    check("clr_lvl",    32'(wr.fifo_lvl_o), 32'd0);
    check("clr_wready", 32'(wr.wready_o),   32'd1);

    // Mid-frame format change and disable: frame completes, no further pop
    set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
    push(8'h3C);
    push(8'h81);
    tx_en = 1'b1;
    cyc = 0; started = 0;
    for (t = 0; t < 500; t++) begin
      @(negedge clk);
      if (busy) begin
        started = 1;
        cyc++;
        if (cyc == 10) begin
          nbits = 2'b00;
          cpb   = CNT_W'(7);
          tx_en = 1'b0;
        end
      end else if (started) begin
        break;
      end
    end
    check("midchg_bounded",     32'(t < 500), 32'd1);
    check("midchg_busy_cycles", 32'(cyc),     32'd40);
    repeat (20) @(negedge clk);
    check("midchg_idle", 32'(busy),           32'd0);
    check("midchg_lvl",  32'(wr.fifo_lvl_o),  32'd1);
    @(negedge clk);
    wr.fifo_clr_i = 1'b1;
    @(negedge clk);
    wr.fifo_clr_i = 1'b0;

    // Asynchronous reset in the middle of DATA
    set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
    push(8'h00);
    push(8'h00);
    tx_en = 1'b1;
    for (t = 0; t < 100 && !busy; t++) @(negedge clk);
    check("rst_wait_busy", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    check("pre_rst_tx",  32'(tx),           32'd0);
    check("pre_rst_lvl", 32'(wr.fifo_lvl_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx",     32'(tx),            32'd1);
    check("async_rst_busy",   32'(busy),          32'd0);
    check("async_rst_lvl",    32'(wr.fifo_lvl_o), 32'd0);
    check("async_rst_wready", 32'(wr.wready_o),   32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, formats and flushes against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wr.wvalid_i   = ($urandom_range(0, 99) < 40);
      wr.wdata_i    = 8'($urandom);
      wr.fifo_clr_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) begin
        set_cfg(int'($urandom_range(0, 3)), 2'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
        tx_en = ($urandom_range(0, 9) != 0);
      end
    end
    @(negedge clk);
    wr.wvalid_i   = 1'b0;
    wr.fifo_clr_i = 1'b0;
    tx_en         = 1'b1;
    repeat (600) @(negedge clk);
    check("drain_lvl",  32'(wr.fifo_lvl_o), 32'd0);
    check("drain_busy", 32'(busy),          32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
